hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
Pipeline hazard and stall scheduler for the 5-stage RISC-V core. It decides each cycle whether the PC and the pipeline registers advance, hold or flush. It uses load-use detection at ID/EX, taken-branch/jump resolution in EX and the data-memory ready handshake in MEM. A small FSM tracks multi-cycle memory waits, branch flushes deferred during a wait, and a memory timeout.

Parameters:
REG_ADDR_W, 5, register index width
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (>=2)
TO_CNT_W, 5, width of timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/jal/jalr (valid 1 cycle)
mem_req  in  1  MEM stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_flush  out  1  ID/EX clear to NOP (bubble)
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
mem_timeout_err  out  1  sticky timeout flag
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 REDIRECT, 3 ERROR

Behaviour:
- Reset: state RUN, pending_redirect=0, to_cnt=0, mem_timeout_err=0. While reset is high, the outputs are pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1 and pipe_hold=0.
- Outputs are combinational from state and the current inputs. State, pending_redirect, to_cnt and err are registered.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- mem_stall = mem_req & ~mem_ready.
- RUN, priority highest first:
  (a) mem_stall: pc_write=0, if_id_write=0, pipe_hold=1, no flush. Capture ex_redirect into pending_redirect. Next state MEM_WAIT, to_cnt=1.
  (b) ex_redirect: pc_write=1, if_id_flush=1, id_ex_flush=1, load_use ignored. Stay in RUN.
  (c) load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Single bubble; the next cycle sees ex_rd of the bubble (0).
  (d) otherwise all enables=1, flushes=0, pipe_hold=0.
- MEM_WAIT: hold outputs as in (a). Any ex_redirect is ORed into pending_redirect; the EX inputs are frozen, so this is the same redirect.
  - mem_ready=1: release pipe_hold this cycle. If pending_redirect, go to REDIRECT, else go to RUN. to_cnt=0.
  - mem_ready=0 with to_cnt==MEM_TIMEOUT-1: next state ERROR, mem_timeout_err<=1. Otherwise to_cnt+1.
- REDIRECT (1 cycle): pc_write=1, if_id_flush=1, id_ex_flush=1, pipe_hold=0. Clear pending_redirect. Next state RUN.
  - If mem_stall is also true here, treat as RUN (a) but keep the flush outputs asserted this cycle.
- ERROR: pc_write=0, if_id_write=0, pipe_hold=1, flushes=0. Leave only by reset. err stays 1.
- to_cnt saturates and never wraps. Reset mid-wait clears everything with no residual pending_redirect.
- ex_rd==0 never stalls. A load whose rd matches but is not used by the ID instruction does not stall.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: add outputs stall_cycles[31:0] and flush_cycles[31:0], both reset to 0.
  - stall_cycles increments on any cycle with pc_write=0 outside reset.
  - flush_cycles increments on any cycle with id_ex_flush=1 outside reset.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle ex_rd=0 -> all enables 1.
- Redirect beats load-use: ex_redirect=1 with a load-use match -> pc_write=1, if_id_flush=1, id_ex_flush=1, state stays RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 for 3 cycles, 0 on the ready cycle, state_o 1,1,1 then 0.
- Deferred redirect: ex_redirect=1 during a 2-cycle wait -> no flush during the wait; the cycle after mem_ready has state_o=2 and both flushes=1, then RUN.
- Timeout: mem_req=1, mem_ready=0 held with MEM_TIMEOUT=16 -> after 16 wait cycles state_o=3 and mem_timeout_err=1, stays there; reset asserted -> RUN and err=0 next cycle.
- Reset mid-wait: assert reset in MEM_WAIT with pending_redirect=1 -> after reset, state RUN, no REDIRECT cycle occurs.

Source files
------------

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: signal bundle between the pipeline and the hazard scheduler.
//   master : pipeline side, drives hazard inputs and observes control
//   slave  : scheduler side, observes hazard inputs and drives control
// Inputs : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 (ID operands),
//          ex_rd/ex_mem_read/ex_redirect (EX result), mem_req/mem_ready (MEM)
// Outputs: pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
//          mem_timeout_err, state_o
interface hazard_sched_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_redirect;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  pipe_hold;
  logic                  mem_timeout_err;
  logic [1:0]            state_o;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout_err, state_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout_err, state_o
  );
endinterface

// File: rtl/hazard_sched.sv
// hazard_sched: stall/flush scheduler for the 5-stage core.
// Decides per cycle whether PC and pipeline registers advance, hold or flush,
// from load-use at ID/EX, EX redirects and the MEM ready handshake. An FSM
// tracks multi-cycle memory waits, redirects deferred across a wait, and a
// memory timeout (sticky error, cleared only by reset).
// Ports:
//   clk, reset    : core clock, synchronous active-high reset
//   hz (slave)    : hazard inputs / pipeline control outputs, see hazard_sched_if
//   stall_cycles, flush_cycles : perf counters, present only when
//                   HAZARD_PERF_CNT_EN is defined
module hazard_sched #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  hazard_sched_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MEM_TIMEOUT - 1);

  state_t                state, state_n;
  logic                  pending, pending_n;
  logic [TO_CNT_W-1:0]   to_cnt, to_cnt_n;
  logic                  err, err_n;

  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c, pipe_hold_c;
  logic load_use, mem_stall;

  // rd==0 is never a real producer, so it never stalls
  assign load_use = hz.ex_mem_read && (hz.ex_rd != {REG_ADDR_W{1'b0}}) &&
                    ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
                     (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
  assign mem_stall = hz.mem_req && !hz.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      pending <= 1'b0;
      to_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      to_cnt  <= to_cnt_n;
      err     <= err_n;
    end
  end

  always_comb begin
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    pipe_hold_c   = 1'b0;
    state_n       = state;
    pending_n     = pending;
    to_cnt_n      = to_cnt;
    err_n         = err;
    case (state)
      S_RUN: begin
        if (mem_stall) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          pipe_hold_c   = 1'b1;
          pending_n     = hz.ex_redirect;
          state_n       = S_WAIT;
          to_cnt_n      = TO_CNT_W'(1);
        end else if (hz.ex_redirect) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
        end
      end
      S_WAIT: begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        pipe_hold_c   = 1'b1;
        // EX is frozen during the wait, so a redirect seen here is the same one
        pending_n     = pending || hz.ex_redirect;
        if (hz.mem_ready) begin
          pipe_hold_c = 1'b0;
          state_n     = pending_n ? S_REDIR : S_RUN;
          to_cnt_n    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n = S_ERR;
          err_n   = 1'b1;
        end else begin
          to_cnt_n = to_cnt + TO_CNT_W'(1);
        end
      end
      S_REDIR: begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        pending_n     = 1'b0;
        state_n       = S_RUN;
        // a new memory stall starts here; the flush still goes out this cycle
        if (mem_stall) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          pipe_hold_c   = 1'b1;
          pending_n     = hz.ex_redirect;
          state_n       = S_WAIT;
          to_cnt_n      = TO_CNT_W'(1);
        end
      end
      default: begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        pipe_hold_c   = 1'b1;
      end
    endcase
    if (reset) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      pipe_hold_c   = 1'b0;
    end
  end

  assign hz.pc_write        = pc_write_c;
  assign hz.if_id_write     = if_id_write_c;
  assign hz.if_id_flush     = if_id_flush_c;
  assign hz.id_ex_flush     = id_ex_flush_c;
  assign hz.pipe_hold       = pipe_hold_c;
  assign hz.mem_timeout_err = err;
  assign hz.state_o         = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_write_c)   stall_cycles <= stall_cycles + 32'd1;
      if (id_ex_flush_c) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the scheduler rules.
module tb_hazard_sched;
  localparam int RW = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_sched_if #(.REG_ADDR_W(RW)) hz_if ();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  hazard_sched #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .TO_CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: mode numbers are the documented state_o values
  int mode;      // 0 run, 1 wait, 2 redirect, 3 error
  bit pend, err;
  int waited;    // stall cycles spent in the current memory wait
  int m_stall, m_flush;

  // expected {state_o, err, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  function automatic logic [7:0] model_out();
    bit ld, ms;
    logic [4:0] c;
    ld = hz_if.ex_mem_read && hz_if.ex_rd != 0 &&
         ((hz_if.id_uses_rs1 && hz_if.id_rs1 == hz_if.ex_rd) ||
          (hz_if.id_uses_rs2 && hz_if.id_rs2 == hz_if.ex_rd));
    ms = hz_if.mem_req && !hz_if.mem_ready;
    if (reset) c = 5'b00110;
    else if (mode == 0) c = ms ? 5'b00001 : hz_if.ex_redirect ? 5'b11110 :
                            ld ? 5'b00010 : 5'b11000;
    else if (mode == 1) c = hz_if.mem_ready ? 5'b00000 : 5'b00001;
    else if (mode == 2) c = ms ? 5'b00111 : 5'b11110;
    else c = 5'b00001;
    return {mode[1:0], err, c};
  endfunction

  function automatic void model_step(input logic [7:0] o);
    bit ms;
    ms = hz_if.mem_req && !hz_if.mem_ready;
    if (reset) begin
      mode = 0; pend = 0; err = 0; waited = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!o[4]) m_stall++;
    if (o[1])  m_flush++;
    case (mode)
      0: if (ms) begin mode = 1; pend = hz_if.ex_redirect; waited = 1; end
      1: begin
        pend = pend | hz_if.ex_redirect;
        if (hz_if.mem_ready) begin mode = pend ? 2 : 0; waited = 0; end
        else begin
          waited++;
          if (waited == TO) begin mode = 3; err = 1; end
        end
      end
      2: begin
        pend = 0;
        if (ms) begin mode = 1; pend = hz_if.ex_redirect; waited = 1; end
        else mode = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] dut_out();
    return {hz_if.state_o, hz_if.mem_timeout_err, hz_if.pc_write, hz_if.if_id_write,
            hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.pipe_hold};
  endfunction

  // inputs are set just after a negedge; check, then advance past the posedge
  task automatic cycle(input string tag);
    logic [7:0] e;
    #1;
    e = model_out();
    chk(tag, {24'd0, dut_out()}, {24'd0, e});
`ifdef HAZARD_PERF_CNT_EN
    if (!reset) begin
      chk({tag, "_stallcnt"}, stall_cycles, m_stall);
      chk({tag, "_flushcnt"}, flush_cycles, m_flush);
    end
`endif
    model_step(e);
    @(negedge clk);
  endtask

  task automatic clr();
    hz_if.id_rs1 = 0; hz_if.id_rs2 = 0; hz_if.id_uses_rs1 = 0; hz_if.id_uses_rs2 = 0;
    hz_if.ex_rd = 0; hz_if.ex_mem_read = 0; hz_if.ex_redirect = 0;
    hz_if.mem_req = 0; hz_if.mem_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1; clr();
    cycle("reset");
    reset = 0;
  endtask

  int longwait;

  initial begin
    reset = 1; clr();
    mode = 0; pend = 0; err = 0; waited = 0; m_stall = 0; m_flush = 0;
    @(negedge clk); @(negedge clk);
    do_reset();

    // load-use: one bubble, then the bubble's rd=0 lets everything advance
    hz_if.ex_mem_read = 1; hz_if.ex_rd = 5; hz_if.id_rs2 = 5; hz_if.id_uses_rs2 = 1;
    #1 chk("lu_pc", hz_if.pc_write, 0);
    chk("lu_bubble", hz_if.id_ex_flush, 1);
    cycle("lu");
    hz_if.ex_rd = 0;
    cycle("lu_next");
    // matching rd but unused operand: no stall
    hz_if.ex_rd = 5; hz_if.id_uses_rs2 = 0; hz_if.id_rs1 = 5;
    cycle("lu_unused");
    clr();

    // redirect beats load-use
    hz_if.ex_mem_read = 1; hz_if.ex_rd = 7; hz_if.id_rs1 = 7; hz_if.id_uses_rs1 = 1;
    hz_if.ex_redirect = 1;
    cycle("redir_lu");
    clr();

    // 3-cycle memory wait then ready
    hz_if.mem_req = 1;
    repeat (3) cycle("memwait");
    hz_if.mem_ready = 1;
    #1 chk("memwait_rdy_hold", hz_if.pipe_hold, 0);
    cycle("memwait_rdy");
    clr();
    #1 chk("memwait_back_run", hz_if.state_o, 0);
    cycle("memwait_after");

    // redirect deferred across a 2-cycle wait
    hz_if.mem_req = 1; hz_if.ex_redirect = 1;
    cycle("defer0");
    cycle("defer1");
    hz_if.mem_ready = 1;
    cycle("defer_rdy");
    clr();
    #1 chk("defer_state", hz_if.state_o, 2);
    cycle("defer_redir");
    cycle("defer_run");

    // timeout
    hz_if.mem_req = 1;
    repeat (TO + 3) cycle("timeout");
    #1 chk("timeout_state", hz_if.state_o, 3);
    chk("timeout_err", hz_if.mem_timeout_err, 1);
    do_reset();
    #1 chk("timeout_rst_err", hz_if.mem_timeout_err, 0);
    cycle("post_timeout");

    // reset in the middle of a wait with a pending redirect
    hz_if.mem_req = 1; hz_if.ex_redirect = 1;
    cycle("rmw0");
    hz_if.ex_redirect = 0;
    cycle("rmw1");
    do_reset();
    #1 chk("rmw_state", hz_if.state_o, 0);
    cycle("rmw_after0");
    #1 chk("rmw_no_redir", hz_if.state_o, 0);
    cycle("rmw_after1");

    // randomized traffic
    longwait = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0) || (mode == 3 && $urandom_range(0, 9) == 0);
      hz_if.id_rs1 = RW'($urandom_range(0, 3));
      hz_if.id_rs2 = RW'($urandom_range(0, 3));
      hz_if.ex_rd  = RW'($urandom_range(0, 3));
      hz_if.id_uses_rs1 = 1'($urandom_range(0, 1));
      hz_if.id_uses_rs2 = 1'($urandom_range(0, 1));
      hz_if.ex_mem_read = 1'($urandom_range(0, 1));
      hz_if.ex_redirect = ($urandom_range(0, 5) == 0);
      if (longwait == 0 && $urandom_range(0, 299) == 0) longwait = TO + 2;
      hz_if.mem_req   = (longwait > 0) || ($urandom_range(0, 2) == 0);
      hz_if.mem_ready = (longwait > 0) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      if (longwait > 0) longwait--;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
